rgb_axis_line_tx: RTL and testbench

AXI4-Stream master that turns a buffered RGB888 pixel source into a video stream. Pixels come from an upstream producer (a frame reader or pattern source) through a valid/ready write port into an internal line FIFO. The block emits them as AXI4-Stream beats, with TUSER marking start-of-frame and TLAST marking end-of-line. It is the transmit end feeding the HDMI path's AXIS pixel sink.

---
 rtl/rgb_axis_pkg.sv | 27 ++
 rtl/rgb_axis_line_tx_if.sv | 33 +++
 rtl/axis_pix_fifo.sv | 89 ++++++++
 rtl/rgb_axis_line_tx.sv | 152 +++++++++++++++
 tb/tb_rgb_axis_line_tx.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_axis_pkg.sv
// Shared constants, state encoding and helpers for the RGB888 AXI4-Stream line transmitter.
package rgb_axis_pkg;

  localparam int PIX_WIDTH      = 24;
  localparam int H_ACTIVE_DEF   = 1280;
  localparam int V_ACTIVE_DEF   = 720;
  localparam int FIFO_DEPTH_DEF = 2048;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Number of address bits needed to index 'value' entries (ceil(log2(value))).
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 32'sd1;
    r = 32'sd0;
    while (v > 32'sd0) begin
      v = v >>> 1;
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rgb_axis_line_tx_if.sv
// AXI4-Stream video bus between the line transmitter and the downstream pixel sink.
interface rgb_axis_line_tx_if
  import rgb_axis_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_WIDTH
) ();

  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic                    tuser;

  modport master (
    output tdata,
    output tstrb,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tstrb,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/axis_pix_fifo.sv
// Synchronous pixel FIFO with registered read port; the read register doubles as the
// transmitter's TDATA output register.
module axis_pix_fifo
  import rgb_axis_pkg::*;
#(
  parameter int WIDTH = PIX_WIDTH,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      empty,
  output logic [clogb2(DEPTH):0]    level
);

  localparam int AW = clogb2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      wr_ptr_s;
  logic [AW:0]      rd_ptr_s;
  logic [AW:0]      level_r;
  logic [WIDTH-1:0] rd_data_r;
  logic             ready_r;
  logic             empty_s;
  logic             wr_s;
  logic             rd_s;
  logic             full_next_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign wr_s    = wr_valid && ready_r;
  assign rd_s    = rd_en && !empty_s;

  // Next pointers and the full flag they imply (MSBs differ, index bits equal).
  always_comb begin
    wr_ptr_s = wr_ptr_r;
    rd_ptr_s = rd_ptr_r;
    if (wr_s) begin
      wr_ptr_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_s = wr_ptr_r;
    end
    if (rd_s) begin
      rd_ptr_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_s = rd_ptr_r;
    end
    full_next_s = (wr_ptr_s[AW] != rd_ptr_s[AW]) &&
                  (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]);
  end

  // Storage array; never reset, a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Pointers, occupancy, ready and the registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= {(AW+1){1'b0}};
      rd_ptr_r  <= {(AW+1){1'b0}};
      level_r   <= {(AW+1){1'b0}};
      ready_r   <= 1'b0;
      rd_data_r <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      level_r  <= wr_ptr_s - rd_ptr_s;
      ready_r  <= !full_next_s;
      if (rd_s) begin
        rd_data_r <= mem_r[rd_ptr_r[AW-1:0]];
      end
    end
  end

  assign wr_ready = ready_r;
  assign rd_data  = rd_data_r;
  assign empty    = empty_s;
  assign level    = level_r;

endmodule

// File: rtl/rgb_axis_line_tx.sv
// AXI4-Stream RGB888 line transmitter: buffers pixels, emits beats with TUSER at
// start-of-frame and TLAST at end-of-line, and only stops at frame boundaries.
module rgb_axis_line_tx
  import rgb_axis_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = PIX_WIDTH,
  parameter int H_ACTIVE             = H_ACTIVE_DEF,
  parameter int V_ACTIVE             = V_ACTIVE_DEF,
  parameter int FIFO_DEPTH           = FIFO_DEPTH_DEF
) (
  input  logic                            M_AXIS_ACLK,
  input  logic                            M_AXIS_ARESETN,
  input  logic                            enable,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] pix_in_data,
  input  logic                            pix_in_valid,
  output logic                            pix_in_ready,
  rgb_axis_line_tx_if.master              m_axis,
  output logic [clogb2(FIFO_DEPTH):0]     fifo_level,
  output logic                            line_done,
  output logic                            frame_done,
  output logic                            underrun
);

  localparam int HW = clogb2(H_ACTIVE + 32'sd1);
  localparam int VW = clogb2(V_ACTIVE + 32'sd1);
  localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 32'sd1);
  localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE - 32'sd1);
  localparam logic [HW-1:0] H_ONE  = HW'(32'sd1);
  localparam logic [VW-1:0] V_ONE  = VW'(32'sd1);

  state_t                          state_r;
  state_t                          state_s;
  logic [HW-1:0]                   h_cnt_r;
  logic [VW-1:0]                   v_cnt_r;
  logic                            tvalid_r;
  logic                            tlast_r;
  logic                            tuser_r;
  logic                            tframe_r;
  logic                            line_done_r;
  logic                            frame_done_r;
  logic                            underrun_r;
  logic                            stall_r;
  logic                            empty_s;
  logic                            hs_s;
  logic                            hold_last_s;
  logic                            load_s;
  logic                            stall_s;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] rd_data_s;

  axis_pix_fifo #(
    .WIDTH (C_M_AXIS_TDATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (M_AXIS_ACLK),
    .rst_n    (M_AXIS_ARESETN),
    .wr_data  (pix_in_data),
    .wr_valid (pix_in_valid),
    .wr_ready (pix_in_ready),
    .rd_en    (load_s),
    .rd_data  (rd_data_s),
    .empty    (empty_s),
    .level    (fifo_level)
  );

  // With enable low, the frame's final beat must not be chased by the next frame's first pixel.
  assign hs_s        = tvalid_r && m_axis.tready;
  assign hold_last_s = tvalid_r && tframe_r && !enable;
  assign load_s      = (state_r == STREAM) && !empty_s && (!tvalid_r || m_axis.tready) && !hold_last_s;
  assign stall_s     = (state_r == STREAM) && (h_cnt_r != {HW{1'b0}}) &&
                       (!tvalid_r || m_axis.tready) && empty_s;

  // Frame-level FSM next state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable && !empty_s) begin
          state_s = STREAM;
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        if (hs_s && tframe_r && !enable) begin
          state_s = IDLE;
        end else begin
          state_s = STREAM;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Output beat register and raster position counters.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
      tuser_r  <= 1'b0;
      tframe_r <= 1'b0;
      h_cnt_r  <= {HW{1'b0}};
      v_cnt_r  <= {VW{1'b0}};
    end else if (load_s) begin
      tvalid_r <= 1'b1;
      tlast_r  <= (h_cnt_r == H_LAST);
      tuser_r  <= (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});
      tframe_r <= (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST);
      if (h_cnt_r == H_LAST) begin
        h_cnt_r <= {HW{1'b0}};
        v_cnt_r <= (v_cnt_r == V_LAST) ? {VW{1'b0}} : (v_cnt_r + V_ONE);
      end else begin
        h_cnt_r <= h_cnt_r + H_ONE;
      end
    end else if (hs_s) begin
      tvalid_r <= 1'b0;
    end
  end

  // Status pulses; underrun fires only on entry into a mid-line stall.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      line_done_r  <= 1'b0;
      frame_done_r <= 1'b0;
      underrun_r   <= 1'b0;
      stall_r      <= 1'b0;
    end else begin
      line_done_r  <= hs_s && tlast_r;
      frame_done_r <= hs_s && tlast_r && tframe_r;
      underrun_r   <= stall_s && !stall_r;
      stall_r      <= stall_s;
    end
  end

  assign m_axis.tdata  = rd_data_s;
  assign m_axis.tstrb  = {(C_M_AXIS_TDATA_WIDTH/8){1'b1}};
  assign m_axis.tvalid = tvalid_r;
  assign m_axis.tlast  = tlast_r;
  assign m_axis.tuser  = tuser_r;
  assign line_done     = line_done_r;
  assign frame_done    = frame_done_r;
  assign underrun      = underrun_r;

endmodule

// File: tb/tb_rgb_axis_line_tx.sv
// Directed bench for rgb_axis_line_tx with a 4x2 frame and an 8-entry FIFO.
module tb_rgb_axis_line_tx;
  import rgb_axis_pkg::*;

  localparam int W = 24;
  localparam int H = 4;
  localparam int V = 2;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [W-1:0]  pix_in_data = 24'h0;
  logic          pix_in_valid = 1'b0;
  logic          pix_in_ready;
  logic [3:0]    fifo_level;
  logic          line_done;
  logic          frame_done;
  logic          underrun;

  int checks = 0;
  int failures = 0;
  int n_line = 0;
  int n_frame = 0;
  int n_under = 0;
  int l0;
  int f0;
  int u0;
  int acc;
  logic was_ready;

  rgb_axis_line_tx_if #(.DATA_WIDTH(W)) m_axis ();

  rgb_axis_line_tx #(
    .C_M_AXIS_TDATA_WIDTH (W),
    .H_ACTIVE             (H),
    .V_ACTIVE             (V),
    .FIFO_DEPTH           (D)
  ) dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst_n),
    .enable         (enable),
    .pix_in_data    (pix_in_data),
    .pix_in_valid   (pix_in_valid),
    .pix_in_ready   (pix_in_ready),
    .m_axis         (m_axis),
    .fifo_level     (fifo_level),
    .line_done      (line_done),
    .frame_done     (frame_done),
    .underrun       (underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (line_done)  n_line  <= n_line + 1;
    if (frame_done) n_frame <= n_frame + 1;
    if (underrun)   n_under <= n_under + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] d);
    pix_in_data  = d;
    pix_in_valid = 1'b1;
    step();
    pix_in_valid = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [W-1:0] d, input logic l,
                             input logic u, input int budget);
    int n = 0;
    while (m_axis.tvalid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_valid"}, {31'd0, m_axis.tvalid}, 32'd1);
    check({tag, "_data"},  {8'd0, m_axis.tdata},   {8'd0, d});
    check({tag, "_last"},  {31'd0, m_axis.tlast},  {31'd0, l});
    check({tag, "_user"},  {31'd0, m_axis.tuser},  {31'd0, u});
    step();
  endtask

  initial begin
    m_axis.tready = 1'b0;

    // Reset state
    #2;
    check("rst_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
    check("rst_tlast",  {31'd0, m_axis.tlast},  32'd0);
    check("rst_tuser",  {31'd0, m_axis.tuser},  32'd0);
    check("rst_tdata",  {8'd0, m_axis.tdata},   32'd0);
    check("rst_level",  {28'd0, fifo_level},    32'd0);
    check("rst_ready",  {31'd0, pix_in_ready},  32'd0);
    check("tstrb",      {29'd0, m_axis.tstrb},  32'd7);
    #10 rst_n = 1'b1;
    step();
    check("rel_ready", {31'd0, pix_in_ready}, 32'd1);

    // Full frame of 8 pixels buffered while disabled, then streamed back to back
    for (int k = 1; k <= 8; k++) push(24'(k));
    check("buf_level",  {28'd0, fifo_level},   32'd8);
    check("buf_ready",  {31'd0, pix_in_ready}, 32'd0);
    check("buf_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
    m_axis.tready = 1'b1;
    enable = 1'b1;
    l0 = n_line;
    f0 = n_frame;
    expect_beat("b1", 24'h000001, 1'b0, 1'b1, 4);
    expect_beat("b2", 24'h000002, 1'b0, 1'b0, 0);
    expect_beat("b3", 24'h000003, 1'b0, 1'b0, 0);
    expect_beat("b4", 24'h000004, 1'b1, 1'b0, 0);
    check("b4_line_done",  {31'd0, line_done},  32'd1);
    check("b4_frame_done", {31'd0, frame_done}, 32'd0);
    expect_beat("b5", 24'h000005, 1'b0, 1'b0, 0);
    expect_beat("b6", 24'h000006, 1'b0, 1'b0, 0);
    expect_beat("b7", 24'h000007, 1'b0, 1'b0, 0);
    expect_beat("b8", 24'h000008, 1'b1, 1'b0, 0);
    check("b8_frame_done", {31'd0, frame_done},   32'd1);
    check("b8_drained",    {31'd0, m_axis.tvalid}, 32'd0);
    step();
    step();
    check("f1_lines",  32'(n_line - l0),  32'd2);
    check("f1_frames", 32'(n_frame - f0), 32'd1);

    // Latency and TREADY back-pressure mid-line
    m_axis.tready = 1'b0;
    push(24'h000011);
    check("lat_wait", {31'd0, m_axis.tvalid}, 32'd1 - 32'd1);
    push(24'h000012);
    check("lat_valid", {31'd0, m_axis.tvalid}, 32'd1);
    check("lat_data",  {8'd0, m_axis.tdata},   32'h11);
    check("lat_user",  {31'd0, m_axis.tuser},  32'd1);
    push(24'h000013);
    push(24'h000014);
    check("bp_hold0", {8'd0, m_axis.tdata}, 32'h11);
    m_axis.tready = 1'b1;
    step();
    check("bp_adv_data", {8'd0, m_axis.tdata},  32'h12);
    check("bp_adv_user", {31'd0, m_axis.tuser}, 32'd0);
    m_axis.tready = 1'b0;
    step();
    check("bp_hold1_valid", {31'd0, m_axis.tvalid}, 32'd1);
    check("bp_hold1_data",  {8'd0, m_axis.tdata},   32'h12);
    step();
    check("bp_hold2_data",  {8'd0, m_axis.tdata},   32'h12);
    check("bp_hold2_last",  {31'd0, m_axis.tlast},  32'd0);
    m_axis.tready = 1'b1;
    expect_beat("s2", 24'h000012, 1'b0, 1'b0, 0);
    expect_beat("s3", 24'h000013, 1'b0, 1'b0, 0);
    expect_beat("s4", 24'h000014, 1'b1, 1'b0, 0);
    check("s4_line_done",  {31'd0, line_done},  32'd1);
    check("s4_frame_done", {31'd0, frame_done}, 32'd0);

    // Underrun after the 2nd pixel of the second line, then resume
    u0 = n_under;
    push(24'h000021);
    push(24'h000022);
    check("u1_data", {8'd0, m_axis.tdata},  32'h21);
    check("u1_user", {31'd0, m_axis.tuser}, 32'd0);
    step();
    check("u2_data", {8'd0, m_axis.tdata}, 32'h22);
    step();
    check("ur_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
    check("ur_pulse",  {31'd0, underrun},      32'd1);
    step();
    check("ur_single", {31'd0, underrun}, 32'd0);
    step();
    step();
    push(24'h000023);
    push(24'h000024);
    expect_beat("u3", 24'h000023, 1'b0, 1'b0, 0);
    expect_beat("u4", 24'h000024, 1'b1, 1'b0, 0);
    check("u4_frame_done", {31'd0, frame_done}, 32'd1);
    check("ur_count", 32'(n_under - u0), 32'd1);

    // enable dropped after the 3rd beat: frame completes, then idle
    m_axis.tready = 1'b0;
    for (int k = 1; k <= 8; k++) push(24'h30 + 24'(k));
    m_axis.tready = 1'b1;
    expect_beat("e1", 24'h000031, 1'b0, 1'b1, 0);
    expect_beat("e2", 24'h000032, 1'b0, 1'b0, 0);
    expect_beat("e3", 24'h000033, 1'b0, 1'b0, 0);
    enable = 1'b0;
    expect_beat("e4", 24'h000034, 1'b1, 1'b0, 0);
    expect_beat("e5", 24'h000035, 1'b0, 1'b0, 0);
    expect_beat("e6", 24'h000036, 1'b0, 1'b0, 0);
    expect_beat("e7", 24'h000037, 1'b0, 1'b0, 0);
    expect_beat("e8", 24'h000038, 1'b1, 1'b0, 0);
    check("e8_frame_done", {31'd0, frame_done}, 32'd1);

    // Fill to full while disabled; no beats leave despite data
    m_axis.tready = 1'b0;
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      pix_in_valid = 1'b1;
      pix_in_data  = 24'h41 + 24'(acc);
      was_ready    = pix_in_ready;
      step();
      if (was_ready) acc++;
    end
    pix_in_valid = 1'b0;
    check("full_accepted", 32'(acc),            32'd8);
    check("full_ready",    {31'd0, pix_in_ready}, 32'd0);
    check("full_level",    {28'd0, fifo_level},   32'd8);
    check("idle_tvalid",   {31'd0, m_axis.tvalid}, 32'd0);
    enable = 1'b1;
    m_axis.tready = 1'b1;
    step();
    check("full_ready_pre", {31'd0, pix_in_ready}, 32'd0);
    step();
    check("full_ready_rel", {31'd0, pix_in_ready}, 32'd1);
    check("full_level_rel", {28'd0, fifo_level},   32'd7);
    expect_beat("g1", 24'h000041, 1'b0, 1'b1, 0);
    expect_beat("g2", 24'h000042, 1'b0, 1'b0, 0);
    expect_beat("g3", 24'h000043, 1'b0, 1'b0, 0);
    expect_beat("g4", 24'h000044, 1'b1, 1'b0, 0);
    expect_beat("g5", 24'h000045, 1'b0, 1'b0, 0);
    expect_beat("g6", 24'h000046, 1'b0, 1'b0, 0);
    expect_beat("g7", 24'h000047, 1'b0, 1'b0, 0);
    expect_beat("g8", 24'h000048, 1'b1, 1'b0, 0);
    check("g8_frame_done", {31'd0, frame_done}, 32'd1);

    // Asynchronous reset mid-line
    m_axis.tready = 1'b0;
    push(24'h000051);
    push(24'h000052);
    push(24'h000053);
    check("pre_rst_user",  {31'd0, m_axis.tuser}, 32'd1);
    check("pre_rst_level", {28'd0, fifo_level},   32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
    check("arst_tuser",  {31'd0, m_axis.tuser},  32'd0);
    check("arst_tlast",  {31'd0, m_axis.tlast},  32'd0);
    check("arst_tdata",  {8'd0, m_axis.tdata},   32'd0);
    check("arst_level",  {28'd0, fifo_level},    32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("arst_rel_ready", {31'd0, pix_in_ready}, 32'd1);
    m_axis.tready = 1'b1;
    push(24'h000061);
    expect_beat("r1", 24'h000061, 1'b0, 1'b1, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
